imem_loader: RTL and testbench

Write-side companion of the instruction memory. Accepts a framed byte stream (e.g. from a UART receiver) over a valid/ready handshake, assembles little-endian 32-bit words and drives the memory write port. Holds the core in reset until a full image has been written and its checksum verified. Sits between the byte source and the instruction memory write port, next to the core reset.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/loader_word_asm.sv | 63 ++++++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_e;

  localparam int unsigned IMEM_W_DEF = 13;
  localparam int unsigned IMEM_WORDS = 2 ** (IMEM_W_DEF - 2);
  localparam int unsigned CNT_W      = 16;

  function automatic logic [31:0] word_addr_to_byte(input logic [29:0] word_ptr);
    return {word_ptr, 2'b00};
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian 4-byte word assembler with byte counter and running XOR of
// every byte taken; word_valid_o pulses for one cycle with the completed word.
module loader_word_asm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o
);

  logic [1:0]  cnt_q,   cnt_d;
  logic [23:0] sh_q,    sh_d;
  logic [31:0] word_q,  word_d;
  logic        wv_q,    wv_d;
  logic [7:0]  csum_q,  csum_d;

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    word_d = word_q;
    csum_d = csum_q;
    wv_d   = 1'b0;
    if (clr_i) begin
      cnt_d  = '0;
      sh_d   = '0;
      csum_d = '0;
    end else if (byte_valid_i) begin
      cnt_d  = cnt_q + 2'd1;
      sh_d   = {byte_i, sh_q[23:8]};
      csum_d = csum_q ^ byte_i;
      if (cnt_q == 2'd3) begin
        wv_d   = 1'b1;
        word_d = {byte_i, sh_q};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      word_q <= '0;
      csum_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      csum_q <= csum_d;
      wv_q   <= wv_d;
    end
  end

  assign last_byte_o  = (cnt_q == 2'd3);
  assign word_valid_o = wv_q;
  assign word_o       = word_q;
  assign csum_o       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory; holds the core in
// reset until a complete, checksum-verified image has been written.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned IMEM_W = IMEM_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  output logic              wen_o,
  output logic [IMEM_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              cpu_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned       PTR_W = IMEM_W - 2;
  localparam logic [CNT_W-1:0]  MAX_N = CNT_W'(2 ** PTR_W);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [PTR_W-1:0]  ptr_q,   ptr_d;
  logic [IMEM_W-1:0] waddr_q, waddr_d;
  logic              rdy_q,   rdy_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
  logic              crst_q,  crst_d;

  logic              accept;
  logic              asm_clr;
  logic              asm_byte;
  logic              asm_last;
  logic              asm_wv;
  logic [31:0]       asm_word;
  logic [7:0]        asm_csum;
  logic [CNT_W-1:0]  n_full;

  assign accept   = s_valid_i & rdy_q;
  assign asm_clr  = start_i & (state_q inside {IDLE, DONE, ERROR});
  assign asm_byte = accept & (state_q == DATA);
  assign n_full   = {s_data_i, cnt_q[7:0]};

  loader_word_asm u_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_byte),
    .byte_i       (s_data_i),
    .last_byte_o  (asm_last),
    .word_valid_o (asm_wv),
    .word_o       (asm_word),
    .csum_o       (asm_csum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (asm_wv) ptr_d = ptr_q + 1'b1;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d = HDR_LO;
          cnt_d   = '0;
          ptr_d   = '0;
        end
      end
      HDR_LO: begin
        if (accept) begin
          cnt_d   = {cnt_q[15:8], s_data_i};
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (accept) begin
          cnt_d = n_full;
          if (n_full > MAX_N)      state_d = ERROR;
          else if (n_full == '0)   state_d = CSUM;
          else                     state_d = DATA;
        end
      end
      DATA: begin
        // Leave on the final byte so the checksum byte can follow during the write cycle.
        if (asm_byte && asm_last && (CNT_W'(ptr_q) == cnt_q - 16'd1)) state_d = CSUM;
      end
      CSUM: begin
        if (accept) state_d = (s_data_i == asm_csum) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase

    rdy_d   = state_d inside {HDR_LO, HDR_HI, DATA, CSUM};
    busy_d  = rdy_d;
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERROR);
    crst_d  = done_d;
    waddr_d = IMEM_W'(word_addr_to_byte(30'(ptr_d)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      waddr_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      crst_q  <= crst_d;
    end
  end

  assign s_ready_o  = rdy_q;
  assign wen_o      = asm_wv;
  assign wdata_o    = asm_word;
  assign waddr_o    = waddr_q;
  assign cpu_rst_no = crst_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-frame loads plus hand-built
// sequences for overflow, full memory, stream gaps and mid-load reset.
module tb_imem_loader;

  localparam int IMEM_W = 13;
  localparam int WORDS  = 2 ** (IMEM_W - 2);

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic              s_valid_i = 1'b0;
  logic [7:0]        s_data_i = 8'h00;
  logic              s_ready_o;
  logic              wen_o;
  logic [IMEM_W-1:0] waddr_o;
  logic [31:0]       wdata_o;
  logic              cpu_rst_no;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  always #5 clk_i = ~clk_i;

  imem_loader #(.IMEM_W(IMEM_W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .s_valid_i  (s_valid_i),
    .s_data_i   (s_data_i),
    .s_ready_o  (s_ready_o),
    .wen_o      (wen_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .cpu_rst_no (cpu_rst_no),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  logic [IMEM_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [31:0]       frame_words[WORDS];

  always @(negedge clk_i) begin
    if (wen_o) begin
      wa_q.push_back(waddr_o);
      wd_q.push_back(wdata_o);
    end
    if (s_valid_i && s_ready_o) acc_cnt++;
  end

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    logic        exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    acc_cnt = 0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    bit got;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    s_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk_i); #1; end
    s_valid_i = 1'b1;
    s_data_i  = b;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk_i);
      if (s_ready_o) got = 1'b1;
      @(posedge clk_i); #1;
    end
    s_valid_i = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL byte_accept_timeout: got no ready expected ready for byte %h", b);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] csum, input int maxgap, input int start_at);
    logic [15:0] nn;
    logic [31:0] w;
    nn = 16'(n);
    send_byte(nn[7:0], maxgap);
    send_byte(nn[15:8], maxgap);
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8], maxgap);
        if (i * 4 + j == start_at) begin
          pulse_start();
          check("busy_after_mid_start", 32'(busy_o), 32'd1);
          check("rst_low_mid_load", 32'(cpu_rst_no), 32'd0);
        end
      end
    end
    send_byte(csum, maxgap);
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk_i);
      if (done_o || err_o) seen = 1'b1;
    end
    repeat (2) @(negedge clk_i);
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL end_timeout: got neither done nor err expected one of them");
    end
  endtask

  task automatic verify_load(input string tag, input int n, input logic exp_done);
    check({tag, "_writes"}, 32'(wa_q.size()), 32'(n));
    for (int k = 0; k < n && k < wa_q.size(); k++) begin
      check({tag, "_waddr"}, 32'(wa_q[k]), 32'(k * 4));
      check({tag, "_wdata"}, wd_q[k], frame_words[k]);
    end
    check({tag, "_done"},    32'(done_o),     32'(exp_done));
    check({tag, "_err"},     32'(err_o),      32'(!exp_done));
    check({tag, "_cpu_rst"}, 32'(cpu_rst_no), 32'(exp_done));
    check({tag, "_busy"},    32'(busy_o),     32'd0);
    check({tag, "_ready"},   32'(s_ready_o),  32'd0);
    check({tag, "_bytes"},   32'(acc_cnt),    32'(3 + 4 * n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   32'(s_ready_o),  32'd0);
    check({tag, "_wen"},     32'(wen_o),      32'd0);
    check({tag, "_waddr"},   32'(waddr_o),    32'd0);
    check({tag, "_wdata"},   wdata_o,         32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst_no), 32'd0);
    check({tag, "_busy"},    32'(busy_o),     32'd0);
    check({tag, "_done"},    32'(done_o),     32'd0);
    check({tag, "_err"},     32'(err_o),      32'd0);
  endtask

  initial begin
    logic [7:0] x;
    int bad;

    // bytes 13 00 00 00 93 00 10 00 XOR to 0x90; EF^BE^AD^DE = 0x22
    vecs[0] = '{2, 32'h0000_0013, 32'h0010_0093, 8'h90, 1'b1};
    vecs[1] = '{2, 32'h0000_0013, 32'h0010_0093, 8'h81, 1'b0};
    vecs[2] = '{2, 32'h0000_0013, 32'h0010_0093, 8'h80, 1'b0};
    vecs[3] = '{0, 32'h0,         32'h0,         8'h00, 1'b1};
    vecs[4] = '{0, 32'h0,         32'h0,         8'h5A, 1'b0};
    vecs[5] = '{1, 32'hDEAD_BEEF, 32'h0,         8'h22, 1'b1};

    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int v = 0; v < 6; v++) begin
      frame_words[0] = vecs[v].w0;
      frame_words[1] = vecs[v].w1;
      clear_log();
      pulse_start();
      send_frame(vecs[v].n, vecs[v].csum, 0, -1);
      wait_end();
      verify_load($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_done);
    end

    // Oversized header: error straight after HDR_HI, later bytes not consumed.
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    wait_end();
    s_valid_i = 1'b1;
    s_data_i  = 8'hAA;
    repeat (5) @(negedge clk_i);
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;
    check("ovf_err",     32'(err_o),      32'd1);
    check("ovf_done",    32'(done_o),     32'd0);
    check("ovf_cpu_rst", 32'(cpu_rst_no), 32'd0);
    check("ovf_writes",  32'(wa_q.size()), 32'd0);
    check("ovf_ready",   32'(s_ready_o),  32'd0);
    check("ovf_bytes",   32'(acc_cnt),    32'd2);

    // Full memory image.
    x = 8'h00;
    for (int i = 0; i < WORDS; i++) begin
      frame_words[i] = $urandom;
      x = x ^ frame_words[i][7:0] ^ frame_words[i][15:8]
            ^ frame_words[i][23:16] ^ frame_words[i][31:24];
    end
    clear_log();
    pulse_start();
    send_frame(WORDS, x, 0, -1);
    wait_end();
    check("full_writes", 32'(wa_q.size()), 32'(WORDS));
    bad = 0;
    for (int k = 0; k < wa_q.size() && k < WORDS; k++)
      if (wa_q[k] !== IMEM_W'(k * 4) || wd_q[k] !== frame_words[k]) bad++;
    check("full_contents_bad", 32'(bad), 32'd0);
    if (wa_q.size() > 0) begin
      check("full_last_waddr", 32'(wa_q[$]), 32'h1FFC);
      check("full_last_wdata", wd_q[$], frame_words[WORDS-1]);
    end
    check("full_done",    32'(done_o),     32'd1);
    check("full_cpu_rst", 32'(cpu_rst_no), 32'd1);

    // Random gaps and a stray start pulse in the middle of DATA.
    frame_words[0] = 32'h0000_0013;
    frame_words[1] = 32'h0010_0093;
    clear_log();
    pulse_start();
    send_frame(2, 8'h90, 3, 2);
    wait_end();
    verify_load("gaps", 2, 1'b1);

    // Asynchronous reset after six data bytes.
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int j = 0; j < 6; j++) begin
      x = (j < 4) ? frame_words[0][8*j +: 8] : frame_words[1][8*(j-4) +: 8];
      send_byte(x, 0);
    end
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (4) @(negedge clk_i);
    check("async_rst_writes", 32'(wa_q.size()), 32'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    clear_log();
    pulse_start();
    send_frame(2, 8'h90, 0, -1);
    wait_end();
    verify_load("after_rst", 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
